// File: rtl/ssd1963_bus_writer.sv
// ssd1963_bus_writer
//   Runs one 8080-style write cycle toward an SSD1963 for each single-cycle
//   Start_clkB pulse. The cycle has three phases:
//     - SETUP : CS#, D/C# and data are valid, WR# is high.
//     - STROBE: WR# is low.
//     - HOLD  : WR# is high, CS# and data are still held.
//   A one-cycle Done_clkB pulse follows the HOLD phase. Every output is
//   registered, so the pins reflect the FSM state one clock later.
//   Optional feature (macro SSD1963_BUS_READ_EN): adds read cycles. These use
//   lcd_rd_n in place of lcd_wr_n, tristate the data bus with lcd_d_oe, and
//   capture lcd_d_in into RdData_clkB.
// Ports:
//   clkB, rst_clkB            clock, synchronous active-high reset
//   Start_clkB                one-cycle request pulse
//   Cmd_clkB, Data_clkB       command flag / write data, sampled at Start
//   Active_clkB, Done_clkB    busy level / completion pulse
//   Overrun_clkB              sticky: Start seen while a cycle was running
//   lcd_cs_n, lcd_dc,
//   lcd_wr_n, lcd_rd_n, lcd_d LCD bus pins
//   (read build) Rd_clkB, lcd_d_in, lcd_d_oe, RdData_clkB
module ssd1963_bus_writer #(
   parameter int DW         = 16,
   parameter int SETUP_CYC  = 1,
   parameter int WR_LOW_CYC = 2,
   parameter int HOLD_CYC   = 1
) (
   input  logic          clkB,
   input  logic          rst_clkB,
   input  logic          Start_clkB,
   input  logic          Cmd_clkB,
   input  logic [DW-1:0] Data_clkB,
`ifdef SSD1963_BUS_READ_EN
   input  logic          Rd_clkB,
   input  logic [DW-1:0] lcd_d_in,
   output logic          lcd_d_oe,
   output logic [DW-1:0] RdData_clkB,
`endif
   output logic          Active_clkB,
   output logic          Done_clkB,
   output logic          Overrun_clkB,
   output logic          lcd_cs_n,
   output logic          lcd_dc,
   output logic          lcd_wr_n,
   output logic          lcd_rd_n,
   output logic [DW-1:0] lcd_d
);

   localparam int MAXP = (SETUP_CYC > WR_LOW_CYC) ?
                         ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                         ((WR_LOW_CYC > HOLD_CYC) ? WR_LOW_CYC : HOLD_CYC);
   localparam int CW = $clog2(MAXP) + 1;

   localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] STROBE_LD = CW'(WR_LOW_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            cmd_q;
   logic [DW-1:0]   data_q;
   logic            accept;
   logic            is_rd;

   assign accept = (state_q == IDLE) && Start_clkB;

   // State register
   always_ff @(posedge clkB) begin
      if (rst_clkB) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: each phase counts down and moves on when the counter is 0
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (Start_clkB) begin
               state_d = SETUP;
               cnt_d   = SETUP_LD;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = STROBE;
               cnt_d   = STROBE_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         STROBE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Request capture; upstream keeps Cmd/Data stable only around Start
   always_ff @(posedge clkB) begin
      if (rst_clkB) begin
         cmd_q  <= 1'b0;
         data_q <= '0;
      end else if (accept) begin
         cmd_q  <= Cmd_clkB;
         data_q <= Data_clkB;
      end
   end

`ifdef SSD1963_BUS_READ_EN
   logic rd_q;

   always_ff @(posedge clkB) begin
      if (rst_clkB)    rd_q <= 1'b0;
      else if (accept) rd_q <= Rd_clkB;
   end

   assign is_rd = rd_q;

   // The pin is low and about to rise: capture at the end of the strobe.
   // The oe term includes the Done cycle (Active still set), which gives a
   // one-cycle turnaround before the bus is driven again.
   always_ff @(posedge clkB) begin
      if (rst_clkB) begin
         lcd_rd_n    <= 1'b1;
         lcd_d_oe    <= 1'b1;
         RdData_clkB <= '0;
      end else begin
         lcd_rd_n <= !((state_q == STROBE) && rd_q);
         lcd_d_oe <= !(rd_q && ((state_q != IDLE) || Active_clkB));
         if (!lcd_rd_n && (state_q != STROBE))
            RdData_clkB <= lcd_d_in;
      end
   end
`else
   assign is_rd    = 1'b0;
   assign lcd_rd_n = 1'b1;
`endif

   // Registered pins, lagging the state by one clock.
   // dc and lcd_d keep their last values while idle.
   always_ff @(posedge clkB) begin
      if (rst_clkB) begin
         Active_clkB  <= 1'b0;
         Done_clkB    <= 1'b0;
         Overrun_clkB <= 1'b0;
         lcd_cs_n     <= 1'b1;
         lcd_wr_n     <= 1'b1;
         lcd_dc       <= 1'b1;
         lcd_d        <= '0;
      end else begin
         Active_clkB  <= (state_q != IDLE);
         // Active still set while the FSM is back in IDLE marks the final cycle
         Done_clkB    <= (state_q == IDLE) && Active_clkB;
         Overrun_clkB <= Overrun_clkB | (Start_clkB && (state_q != IDLE));
         lcd_cs_n     <= (state_q == IDLE);
         lcd_wr_n     <= !((state_q == STROBE) && !is_rd);
         if (state_q != IDLE) begin
            lcd_dc <= ~cmd_q;
            lcd_d  <= data_q;
         end
      end
   end

endmodule

// File: tb/tb_ssd1963_bus_writer.sv
module tb_ssd1963_bus_writer;

   typedef struct {
      int          cyc;
      logic        cs_n, wr_n, rd_n, dc, done, act, ovr, oe, chk_rd;
      logic [15:0] d, rdd;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT0: default timing. DUT1: SETUP=3, WR_LOW=1, HOLD=2.
   logic        s0 = 0, c0 = 0, r0 = 0, s1 = 0, c1 = 0, r1 = 0;
   logic [15:0] d0 = 0, d1 = 0, din0 = 0, din1 = 0;
   logic        a0, dn0, o0, cs0, dc0, wr0, rdn0, oe0;
   logic        a1, dn1, o1, cs1, dc1, wr1, rdn1, oe1;
   logic [15:0] ld0, ld1, rdd0, rdd1;

`ifndef SSD1963_BUS_READ_EN
   assign oe0 = 1'b1; assign rdd0 = '0;
   assign oe1 = 1'b1; assign rdd1 = '0;
`endif

   ssd1963_bus_writer #(.DW(16), .SETUP_CYC(1), .WR_LOW_CYC(2), .HOLD_CYC(1)) u0 (
      .clkB(clk), .rst_clkB(rst), .Start_clkB(s0), .Cmd_clkB(c0), .Data_clkB(d0),
`ifdef SSD1963_BUS_READ_EN
      .Rd_clkB(r0), .lcd_d_in(din0), .lcd_d_oe(oe0), .RdData_clkB(rdd0),
`endif
      .Active_clkB(a0), .Done_clkB(dn0), .Overrun_clkB(o0), .lcd_cs_n(cs0),
      .lcd_dc(dc0), .lcd_wr_n(wr0), .lcd_rd_n(rdn0), .lcd_d(ld0));

   ssd1963_bus_writer #(.DW(16), .SETUP_CYC(3), .WR_LOW_CYC(1), .HOLD_CYC(2)) u1 (
      .clkB(clk), .rst_clkB(rst), .Start_clkB(s1), .Cmd_clkB(c1), .Data_clkB(d1),
`ifdef SSD1963_BUS_READ_EN
      .Rd_clkB(r1), .lcd_d_in(din1), .lcd_d_oe(oe1), .RdData_clkB(rdd1),
`endif
      .Active_clkB(a1), .Done_clkB(dn1), .Overrun_clkB(o1), .lcd_cs_n(cs1),
      .lcd_dc(dc1), .lcd_wr_n(wr1), .lcd_rd_n(rdn1), .lcd_d(ld1));

   exp_t q0[$];
   exp_t q1[$];
   int n_chk = 0, n_pass = 0;

   task automatic push(input int sel, input exp_t e);
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   // Expected pin trace for one bus cycle started (Start sampled) at edge n.
   // Cycle j after n: 1..S setup, S+1..S+W strobe, then hold, Done at T.
   task automatic push_w(input int sel, input int n, input logic cmd,
                         input logic [15:0] data, input logic rd,
                         input logic [15:0] rdexp, input int S, input int W,
                         input int H, input int ovr_from, input int jmax);
      int   T;
      logic stb;
      exp_t e;
      T = S + W + H + 1;
      for (int j = 1; j <= jmax; j++) begin
         stb      = (j > S) && (j <= S + W);
         e.cyc    = n + j;
         e.cs_n   = !(j < T);
         e.wr_n   = !(stb && !rd);
         e.rd_n   = !(stb && rd);
         e.dc     = !cmd;
         e.d      = data;
         e.done   = (j == T);
         e.act    = (j < T);
         e.ovr    = (n + j >= ovr_from);
         e.oe     = !(rd && (j <= T));
         e.chk_rd = rd && (j == T);
         e.rdd    = rdexp;
         push(sel, e);
      end
   endtask

   task automatic push_idle(input int sel, input int c);
      exp_t e;
      e.cyc = c; e.cs_n = 1; e.wr_n = 1; e.rd_n = 1; e.dc = 1; e.d = '0;
      e.done = 0; e.act = 0; e.ovr = 0; e.oe = 1; e.chk_rd = 0; e.rdd = '0;
      push(sel, e);
   endtask

   task automatic cmp(input string nm, input exp_t e, input logic [22:0] got,
                      input logic goe, input logic [15:0] grd);
      logic [22:0] ex;
      ex = {e.cs_n, e.wr_n, e.rd_n, e.dc, e.done, e.act, e.ovr, e.d};
      n_chk++;
      if (got === ex) n_pass++;
      else $display("FAIL %s cyc=%0d {cs,wr,rd,dc,done,act,ovr,d} got=%h exp=%h",
                    nm, e.cyc, got, ex);
`ifdef SSD1963_BUS_READ_EN
      n_chk++;
      if (goe === e.oe) n_pass++;
      else $display("FAIL %s_oe cyc=%0d got=%b exp=%b", nm, e.cyc, goe, e.oe);
      if (e.chk_rd) begin
         n_chk++;
         if (grd === e.rdd) n_pass++;
         else $display("FAIL %s_rddata cyc=%0d got=%h exp=%h", nm, e.cyc, grd, e.rdd);
      end
`endif
   endtask

   // Monitor: compare the DUT pins whenever an expected entry is due
   always @(negedge clk) begin
      while (q0.size() > 0 && q0[0].cyc < cyc) begin
         n_chk++;
         $display("FAIL dut0_stale cyc=%0d got=missed exp=checked", q0[0].cyc);
         void'(q0.pop_front());
      end
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
         cmp("dut0", q0[0], {cs0, wr0, rdn0, dc0, dn0, a0, o0, ld0}, oe0, rdd0);
         void'(q0.pop_front());
      end
      while (q1.size() > 0 && q1[0].cyc < cyc) begin
         n_chk++;
         $display("FAIL dut1_stale cyc=%0d got=missed exp=checked", q1[0].cyc);
         void'(q1.pop_front());
      end
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
         cmp("dut1", q1[0], {cs1, wr1, rdn1, dc1, dn1, a1, o1, ld1}, oe1, rdd1);
         void'(q1.pop_front());
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // Issue a one-cycle Start at the current negedge; n = edge that samples it
   task automatic pulse(input int sel, input logic cmd, input logic [15:0] data,
                        input logic rd, output int n);
      if (sel == 0) begin s0 = 1; c0 = cmd; d0 = data; r0 = rd; end
      else          begin s1 = 1; c1 = cmd; d1 = data; r1 = rd; end
      n = cyc + 1;
      @(negedge clk);
      s0 = 0; s1 = 0; r0 = 0; r1 = 0;
   endtask

   initial begin
      int n, n2;
      // reset held for 3 edges, then released
      for (int c = 1; c <= 5; c++) begin push_idle(0, c); push_idle(1, c); end
      @(negedge clk);
      wait_cyc(3);
      rst = 0;

      // single data write, default timing
      wait_cyc(6);
      pulse(0, 1'b0, 16'hA5C3, 1'b0, n);
      push_w(0, n, 1'b0, 16'hA5C3, 1'b0, 16'h0, 1, 2, 1, 1 << 30, 6);

      // command write on the slow-timing instance
      wait_cyc(14);
      pulse(1, 1'b1, 16'h002C, 1'b0, n);
      push_w(1, n, 1'b1, 16'h002C, 1'b0, 16'h0, 3, 1, 2, 1 << 30, 8);

      // back-to-back: second Start lands on the Done cycle
      wait_cyc(25);
      pulse(0, 1'b0, 16'h1111, 1'b0, n);
      push_w(0, n, 1'b0, 16'h1111, 1'b0, 16'h0, 1, 2, 1, 1 << 30, 5);
      wait_cyc(n + 4);
      pulse(0, 1'b1, 16'h2222, 1'b0, n2);
      push_w(0, n2, 1'b1, 16'h2222, 1'b0, 16'h0, 1, 2, 1, 1 << 30, 6);

      // overrun: stray Start (with different data) while active
      wait_cyc(40);
      pulse(0, 1'b0, 16'hBEEF, 1'b0, n);
      push_w(0, n, 1'b0, 16'hBEEF, 1'b0, 16'h0, 1, 2, 1, n + 2, 6);
      wait_cyc(n + 1);
      s0 = 1; c0 = 1; d0 = 16'h0000;
      @(negedge clk);
      s0 = 0;

      // reset during STROBE: next edge returns pins to reset values, no Done
      wait_cyc(50);
      pulse(0, 1'b0, 16'h5A5A, 1'b0, n);
      push_w(0, n, 1'b0, 16'h5A5A, 1'b0, 16'h0, 1, 2, 1, 0, 2);
      for (int c = n + 3; c <= n + 6; c++) push_idle(0, c);
      wait_cyc(n + 2);
      rst = 1;
      @(negedge clk);
      rst = 0;

`ifdef SSD1963_BUS_READ_EN
      // read cycle: rd_n strobes, bus released, data captured by Done
      wait_cyc(64);
      din0 = 16'h1234;
      pulse(0, 1'b0, 16'h0000, 1'b1, n);
      push_w(0, n, 1'b0, 16'h0000, 1'b1, 16'h1234, 1, 2, 1, 1 << 30, 6);
`endif

      for (int k = 0; k < 200 && (q0.size() > 0 || q1.size() > 0); k++)
         @(negedge clk);
      if (q0.size() > 0 || q1.size() > 0) begin
         n_chk++;
         $display("FAIL drain got=%0d exp=0 pending entries", q0.size() + q1.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
